// File: rtl/ps2_event_fifo.sv
// PS/2 scancode decoder feeding a show-ahead event FIFO; optional typematic filter via PS2_TYPEMATIC_FILTER_EN.
// Latency: event completed in cycle N is visible from N+1. Backpressure: none upstream; full FIFO drops and flags overflow.
module ps2_event_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               i_byte,
  input  logic                     i_byte_valid,
  input  logic                     i_pop,
  input  logic                     i_clr_ovf,
  output logic [9:0]               o_event,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [9:0]      mem [DEPTH];

  logic            dec_vld;
  logic            dec_brk;
  logic            dec_ext;
  logic            push_vld;
  logic            push_ok;
  logic            pop_ok;
  logic            full;
  logic            is_prefix;
  logic            is_ignored;

  assign is_prefix  = (i_byte == 8'hE0) || (i_byte == 8'hF0);
  assign is_ignored = (i_byte == 8'h00) || (i_byte == 8'hAA) || (i_byte == 8'hFA) ||
                      (i_byte == 8'hFE) || (i_byte == 8'hFF);

  always_comb begin
    state_d = state_q;
    dec_vld = 1'b0;
    dec_brk = 1'b0;
    dec_ext = 1'b0;
    if (i_byte_valid) begin
      case (state_q)
        IDLE: begin
          if (i_byte == 8'hE0)      state_d = EXT;
          else if (i_byte == 8'hF0) state_d = BRK;
          else if (!is_ignored)     dec_vld = 1'b1;
        end
        EXT: begin
          if (i_byte == 8'hF0) begin
            state_d = EXT_BRK;
          end else if (i_byte != 8'hE0) begin
            dec_vld = 1'b1;
            dec_ext = 1'b1;
            state_d = IDLE;
          end
        end
        BRK: begin
          // A second prefix inside a break sequence is malformed; abandon it.
          dec_vld = !is_prefix;
          dec_brk = 1'b1;
          state_d = IDLE;
        end
        default: begin
          dec_vld = !is_prefix;
          dec_brk = 1'b1;
          dec_ext = 1'b1;
          state_d = IDLE;
        end
      endcase
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic       last_vld_q, last_vld_d;
  logic       last_ext_q, last_ext_d;
  logic [7:0] last_code_q, last_code_d;
  logic       last_match;

  assign last_match = last_vld_q && (last_ext_q == dec_ext) && (last_code_q == i_byte);
  assign push_vld   = dec_vld && !(last_match && !dec_brk);

  always_comb begin
    last_vld_d  = last_vld_q;
    last_ext_d  = last_ext_q;
    last_code_d = last_code_q;
    if (push_ok && !dec_brk) begin
      last_vld_d  = 1'b1;
      last_ext_d  = dec_ext;
      last_code_d = i_byte;
    end else if (dec_vld && dec_brk && last_match) begin
      last_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_vld_q  <= 1'b0;
      last_ext_q  <= 1'b0;
      last_code_q <= 8'h00;
    end else begin
      last_vld_q  <= last_vld_d;
      last_ext_q  <= last_ext_d;
      last_code_q <= last_code_d;
    end
  end
`else
  assign push_vld = dec_vld;
`endif

  assign full    = (count_q == CW'(DEPTH));
  assign pop_ok  = i_pop && (count_q != '0);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_ok = push_vld && (!full || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
    else if (pop_ok && !push_ok) count_d = count_q - CW'(1);
    if (i_clr_ovf) ovf_d = 1'b0;
    if (push_vld && !push_ok) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= {dec_brk, dec_ext, i_byte};
  end

  assign o_event    = mem[rd_ptr_q];
  assign o_empty    = (count_q == '0);
  assign o_count    = count_q;
  assign o_overflow = ovf_q;

endmodule

// File: doc/ps2_event_fifo.md
PS2_EVENT_FIFO -- requirements
Module: ps2_event_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, event FIFO depth; power of two, 2..256.
REQ-002 SHALL have port clk  input  1  single clock domain; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port i_byte  input  8  scancode byte from the PS/2 receiver.
REQ-005 SHALL have port i_byte_valid  input  1  one-cycle strobe qualifying i_byte.
REQ-006 SHALL have port i_pop  input  1  CPU read strobe; removes the head event.
REQ-007 SHALL have port i_clr_ovf  input  1  clears the sticky overflow flag.
REQ-008 SHALL have port o_event  output  10  head event: [9]=break, [8]=extended (E0), [7:0]=scancode.
REQ-009 SHALL have port o_empty  output  1  FIFO holds no events.
REQ-010 SHALL have port o_count  output  $clog2(DEPTH)+1  number of stored events.
REQ-011 SHALL have port o_overflow  output  1  sticky; an event was dropped because the FIFO was full.

Function
REQ-012 Decoder FSM SHALL have states IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen); it advances only on cycles with i_byte_valid=1.
REQ-013 IDLE: 0xE0 -> EXT; 0xF0 -> BRK; 0x00, 0xAA, 0xFA, 0xFE, 0xFF -> discarded, stay IDLE; any other byte -> push {0,0,byte}, stay IDLE.
REQ-014 EXT: 0xF0 -> EXT_BRK; 0xE0 -> stay EXT; any other byte -> push {0,1,byte}, go IDLE.
REQ-015 BRK: any byte other than 0xE0/0xF0 -> push {1,0,byte}, go IDLE; 0xE0 or 0xF0 -> discard sequence, go IDLE.
REQ-016 EXT_BRK: any byte other than 0xE0/0xF0 -> push {1,1,byte}, go IDLE; 0xE0 or 0xF0 -> discard sequence, go IDLE.
REQ-017 FIFO SHALL be show-ahead: o_event equals the oldest stored event whenever o_empty=0; o_event is don't-care when empty.
REQ-018 Latency: event completed by the byte strobe in cycle N SHALL be visible on o_event/o_count, with o_empty=0, from cycle N+1.
REQ-019 i_pop with o_empty=0 SHALL advance the read pointer; o_count decrements at the next edge. i_pop with o_empty=1 SHALL be ignored.
REQ-020 Push while o_count==DEPTH with no simultaneous pop SHALL drop the new event, leave FIFO contents unchanged, and set o_overflow.
REQ-021 Simultaneous push and pop SHALL both take effect, o_count unchanged, including when the FIFO is full (no overflow) or holds exactly 1 event.
REQ-022 Read/write pointers SHALL wrap modulo DEPTH; o_count SHALL never exceed DEPTH.
REQ-023 i_clr_ovf SHALL clear o_overflow at the next edge; if an overflow occurs in the same cycle, set SHALL win.

Reset
REQ-024 When rst=1 at a clock edge: FSM -> IDLE, pointers -> 0, o_count=0, o_empty=1, o_overflow=0, typematic register invalid; storage contents need not be cleared.
REQ-025 Reset asserted mid-sequence (e.g. after 0xE0) SHALL abandon the partial sequence; no event is pushed for it.

Configuration
REQ-026 Macro PS2_TYPEMATIC_FILTER_EN SHALL, when defined, hold a last-make register {valid, ext, code}: a make event equal to it SHALL be dropped (no push, no overflow); any pushed make loads it; a break matching it clears valid.
REQ-027 Without PS2_TYPEMATIC_FILTER_EN, every decoded make event SHALL be pushed, including typematic repeats.

Verification
REQ-028 Bytes 0x1C -> one event 0x01C visible the cycle after the strobe; o_count=1.
REQ-029 Bytes E0 F0 75 -> single event 0x375; bytes AA FA -> no event, FIFO stays empty.
REQ-030 DEPTH=16: push 17 make codes with no pop -> o_count=16, o_overflow=1, head is the first code; i_clr_ovf -> o_overflow=0.
REQ-031 Full FIFO plus final-byte strobe and i_pop in the same cycle -> o_count stays 16, o_overflow stays 0, newest event at tail.
REQ-032 Bytes E0 then rst pulse then 0x6B -> single event 0x06B (not extended).
REQ-033 Bytes 1C 1C 1C F0 1C: with PS2_TYPEMATIC_FILTER_EN events 0x01C, 0x21C; without it 0x01C x3, 0x21C.
